// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: ROM address/data, decode handshake, redirect request and status.
// The master modport is the fetch sequencer; the slave modport is the ROM/decode/branch side.
interface ifetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr,
        input  imem_instr,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr,
        input  redirect_valid,
        input  redirect_pc,
        output fault,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr,
        output redirect_valid,
        output redirect_pc,
        input  fault,
        input  fetch_count
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers ROM words in a small FIFO
// and hands {pc, instr} to decode; redirects flush the FIFO, bad addresses raise a sticky fault.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  ST_FETCH  | fetching from fpc whenever it is legal and the FIFO has room
//  ST_FAULT  | sticky address fault; fpc frozen, FIFO drains, wait for redirect
module ifetch_ctrl #(
    parameter int          MEM_SIZE = 1024,
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    ifetch_ctrl_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [64:0]   MEM_LIMIT = 65'(MEM_SIZE);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [63:0]   fpc_q, fpc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   fcnt_q, fcnt_d;
    logic [63:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic legal;
    logic valid;
    logic full;
    logic pop;
    logic push;

    // 65-bit sum so an address near 2^64 cannot wrap into range
    assign legal = (fpc_q[1:0] == 2'b00) && (({1'b0, fpc_q} + 65'd3) < MEM_LIMIT);
    assign valid = (count_q != '0);
    assign full  = (count_q == CNT_FULL);
    assign pop   = valid & bus.if_ready;
    assign push  = ~bus.redirect_valid & (state_q == ST_FETCH) & legal & (~full | pop);

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fcnt_d   = fcnt_q;

        if (bus.redirect_valid) begin
            // flush wins over everything, including a pop presented this cycle
            state_d  = ST_FETCH;
            fpc_d    = bus.redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if ((state_q == ST_FETCH) && !legal) begin
                state_d = ST_FAULT;
            end
            if (push) begin
                fpc_d    = fpc_q + 64'd4;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                fcnt_d   = fcnt_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_FETCH;
            fpc_q    <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fcnt_q   <= fcnt_d;
        end
    end

    // ROM data is captured only on a legal push, so X from an unmapped read never lands here
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= fpc_q;
            instr_mem_q[wr_ptr_q] <= bus.imem_instr;
        end
    end

    assign bus.imem_addr   = fpc_q;
    assign bus.if_valid    = valid;
    assign bus.if_pc       = valid ? pc_mem_q[rd_ptr_q] : 64'd0;
    assign bus.if_instr    = valid ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.fetch_count = fcnt_q;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: directed phases queue the {pc, instr} decode should
// accept, and a negedge monitor pops and compares every accepted head entry.
module tb_ifetch_ctrl;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    ifetch_ctrl_if bus ();

    ifetch_ctrl #(
        .MEM_SIZE (1024),
        .RESET_PC (64'd0),
        .DEPTH    (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // ROM model: word k (byte address 4k) holds k+100
    assign bus.imem_instr = 32'(bus.imem_addr >> 2) + 32'd100;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'(pc >> 2) + 32'd100;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.if_valid === 1'b1 && bus.if_ready === 1'b1
            && bus.redirect_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_pop: got pc 0x%0h, expected no accepted entry", bus.if_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("head_pc", bus.if_pc, mon_e.pc);
                chk("head_instr", 64'(bus.if_instr), 64'(mon_e.instr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n            = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        repeat (2) tick;
        chk("rst_valid", 64'(bus.if_valid), 64'd0);
        chk("rst_fault", 64'(bus.fault), 64'd0);
        chk("rst_count", 64'(bus.fetch_count), 64'd0);
        chk("rst_addr", bus.imem_addr, 64'd0);
        chk("rst_if_pc", bus.if_pc, 64'd0);
        chk("rst_if_instr", 64'(bus.if_instr), 64'd0);

        // streaming with decode always ready
        bus.if_ready = 1'b1;
        push_exp(64'd0); push_exp(64'd4); push_exp(64'd8); push_exp(64'd12);
        reset_n = 1'b1;
        repeat (5) tick;
        bus.if_ready = 1'b0;
        chk("p1_count", 64'(bus.fetch_count), 64'd4);
        chk("p1_drained", 64'(exp_q.size()), 64'd0);
        chk("p1_valid", 64'(bus.if_valid), 64'd1);

        // asynchronous reset between edges
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.if_valid), 64'd0);
        chk("mid_rst_count", 64'(bus.fetch_count), 64'd0);
        chk("mid_rst_addr", bus.imem_addr, 64'd0);
        tick;
        tick;

        // backpressure: FIFO fills with pc 0,4 and fpc parks at 8
        reset_n = 1'b1;
        repeat (5) tick;
        chk("p2_addr", bus.imem_addr, 64'd8);
        chk("p2_head_pc", bus.if_pc, 64'd0);
        chk("p2_valid", 64'(bus.if_valid), 64'd1);
        push_exp(64'd0); push_exp(64'd4);
        bus.if_ready = 1'b1;
        tick;
        tick;
        chk("p3_head_pre_redirect", bus.if_pc, 64'd8);

        // redirect while a pop is offered: pop is discarded
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h40;
        tick;
        bus.redirect_valid = 1'b0;
        chk("p3_valid_gap", 64'(bus.if_valid), 64'd0);
        chk("p3_count_after_flush", 64'(bus.fetch_count), 64'd2);
        chk("p3_addr", bus.imem_addr, 64'h40);
        push_exp(64'h40); push_exp(64'h44);
        repeat (3) tick;
        bus.if_ready = 1'b0;
        chk("p3_count", 64'(bus.fetch_count), 64'd4);

        // last legal word, then out-of-range fault
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h3FC;
        tick;
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b1;
        push_exp(64'h3FC);
        tick;
        tick;
        chk("p4_fault", 64'(bus.fault), 64'd1);
        chk("p4_valid", 64'(bus.if_valid), 64'd0);
        chk("p4_addr", bus.imem_addr, 64'h400);
        chk("p4_count", 64'(bus.fetch_count), 64'd5);

        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h10;
        tick;
        bus.redirect_valid = 1'b0;
        chk("p4_fault_clear", 64'(bus.fault), 64'd0);
        push_exp(64'h10);
        tick;
        tick;
        bus.if_ready = 1'b0;
        chk("p4_count_after", 64'(bus.fetch_count), 64'd6);

        // misaligned target
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h22;
        tick;
        bus.redirect_valid = 1'b0;
        chk("p5_fault_pre", 64'(bus.fault), 64'd0);
        chk("p5_valid_pre", 64'(bus.if_valid), 64'd0);
        tick;
        chk("p5_fault", 64'(bus.fault), 64'd1);
        chk("p5_addr", bus.imem_addr, 64'h22);
        bus.if_ready = 1'b1;
        repeat (3) tick;
        chk("p5_valid_hold", 64'(bus.if_valid), 64'd0);
        chk("p5_addr_hold", bus.imem_addr, 64'h22);
        chk("p5_fault_hold", 64'(bus.fault), 64'd1);
        chk("p5_count_hold", 64'(bus.fetch_count), 64'd6);

        // reset clears a sticky fault immediately, then fetch restarts at RESET_PC
        bus.if_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst2_fault", 64'(bus.fault), 64'd0);
        chk("rst2_count", 64'(bus.fetch_count), 64'd0);
        chk("rst2_addr", bus.imem_addr, 64'd0);
        tick;
        tick;
        push_exp(64'd0); push_exp(64'd4);
        bus.if_ready = 1'b1;
        reset_n      = 1'b1;
        repeat (3) tick;
        bus.if_ready = 1'b0;
        chk("rst2_restart_count", 64'(bus.fetch_count), 64'd2);
        chk("rst2_head_pc", bus.if_pc, 64'd8);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read instruction ROM.
- Owns the fetch PC and drives the ROM address.
- Buffers fetched words in a small FIFO.
- Presents {pc, instruction} to decode over a valid/ready handshake.
- Handles branch redirects with a flush, and raises a sticky fault on misaligned or out-of-range fetch addresses.

Parameters:
MEM_SIZE, 1024, ROM size in bytes (power of two, >4).
RESET_PC, 64'd0, fetch PC loaded at reset.
DEPTH, 2, fetch FIFO entries (power of two, >=2).

Ports:
clk  input  1  clock; all state updates on posedge.
reset_n  input  1  asynchronous, active-low reset.
imem_addr  output  64  byte address to ROM; always equals the fetch PC (fpc).
imem_instr  input  32  combinational ROM read data for imem_addr.
if_valid  output  1  FIFO head holds a valid entry.
if_ready  input  1  decode accepts head this cycle.
if_pc  output  64  PC of head entry.
if_instr  output  32  instruction of head entry.
redirect_valid  input  1  branch taken / flush request.
redirect_pc  input  64  new fetch target.
fault  output  1  sticky fetch-address fault.
fetch_count  output  32  number of entries accepted by decode since reset.

Behaviour:
- Reset (reset_n low, async): fpc=RESET_PC, FIFO empty, if_valid=0, fault=0, fetch_count=0. if_pc and if_instr read 0 while empty.
- pop = if_valid & if_ready.
- legal = (fpc[1:0]==0) & (fpc+3 < MEM_SIZE), computed at 64-bit width with no wrap.
- push = ~redirect_valid & ~fault & legal & (count<DEPTH | pop).
  - Push writes {fpc, imem_instr} to the FIFO tail and sets fpc <= fpc+4.
- Fault:
  - If ~redirect_valid & ~fault & ~legal, then fault <= 1 and nothing is pushed.
  - While fault=1, fetch stops and fpc holds. The FIFO continues to drain to decode.
- Latency:
  - A word pushed at edge N is visible as the head after N if the FIFO was empty.
  - First if_valid=1 is after the first posedge following reset release.
- Simultaneous push and pop when full is allowed; count stays DEPTH. Push and pop at count 0 is impossible (pop requires valid).
- Redirect (highest priority) at edge N:
  - FIFO flushed to count 0; any pop in that cycle is discarded and not counted.
  - fpc <= redirect_pc; fault <= 0; no push.
  - Edge N+1 fetches the target (or faults if it is illegal).
  - if_valid is 0 during N→N+1 and 1 after N+1.
- Head outputs hold stable while if_valid & ~if_ready, except on redirect.
- fetch_count increments by 1 per non-flushed pop and wraps at 2^32.
- Counter is DEPTH-wide+1 (0..DEPTH). Pointers wrap modulo DEPTH.
- Reset asserted mid-operation takes effect immediately: outputs return to reset values asynchronously.
- No X propagation into the FIFO: imem_instr is sampled only on a legal push.

Test Plan:
- Reset release, if_ready=1 constantly, ROM word k=k+100 → if_pc sequence 0,4,8,12 with instr 100,101,102,103, one per cycle after the first edge. fetch_count=4 after 4 pops.
- if_ready=0 for 5 cycles after reset → FIFO fills to 2 entries (pc 0,4); fpc holds at 8; head stays pc=0. Raise if_ready → pcs 0,4,8 delivered in consecutive cycles.
- redirect_valid with redirect_pc=0x40 while FIFO holds pc 8,12 and if_ready=1 → that pop is discarded (fetch_count unchanged); if_valid=0 for one cycle; next head pc=0x40 then 0x44.
- redirect_pc=0x3FC → pc 0x3FC delivered; next fetch at 0x400 sets fault=1 and no push. Redirect to 0x10 clears fault and delivers pc 0x10.
- redirect_pc=0x22 (misaligned) → fault=1 one edge later, if_valid stays 0, imem_addr holds 0x22.
- Assert reset_n low mid-stream between edges → if_valid, fault and fetch_count go to 0 immediately; after release, fetch restarts at RESET_PC.
